cmd_issuer: RTL and testbench
=============================

// Module: cmd_issuer
// PURPOSE
//  Controller-side DDR4 command generator, the transmit end of the CMD pin decoder.
//  Accepts one memory request at a time (rd/wr, bg, ba, row, col) on a valid/ready port.
//  Drives the cke/cs_n/act_n/bg/ba/A pin bundle with a timed ACT -> RD/WR -> PRE sequence.
//  Sits between the request source (host/trace player) and the CMD + bank models.
// PARAMETERS
//  ADDRWIDTH  17  width of A and of the row address
//  COLWIDTH   10  column address width; driven on A[COLWIDTH-1:0]
//  BGWIDTH    2   bank-group select width
//  BAWIDTH    2   bank select width
//  BL         8   burst length in clock cycles, counted from the CAS cycle
//  TRCD       4   cycles from ACT to CAS, >=1
//  TRP        4   cycles from PRE to the next ACT or to done, >=1
// PORTS
//  clk          in   1          clock; all logic on posedge
//  rst_n        in   1          synchronous, active-low reset
//  req_valid    in   1          request present
//  req_ready    out  1          high only in IDLE; accept = req_valid & req_ready
//  req_rd_o_wr  in   1          1 = write, 0 = read (same sense as decoder rd_o_wr)
//  req_bg       in   BGWIDTH    target bank group
//  req_ba       in   BAWIDTH    target bank
//  req_row      in   ADDRWIDTH  row address
//  req_col      in   COLWIDTH   start column
//  cke          out  1          clock enable pin; 1 whenever out of reset
//  cs_n         out  1          chip select pin; 0 only on command cycles
//  act_n        out  1          activate pin
//  bg           out  BGWIDTH    bank group pins
//  ba           out  BAWIDTH    bank pins
//  A            out  ADDRWIDTH  address/command pins; A[top:top-2] = RAS_n,CAS_n,WE_n
//  busy         out  1          ~req_ready
//  done         out  1          one-cycle pulse when a request completes
// BEHAVIOUR
//  - All outputs registered. Reset value: cke=1, cs_n=1, act_n=1, bg=0, ba=0,
//    A={3'b111,0} (17'h1C000), req_ready=1, busy=0, done=0. FSM to IDLE. Counters to 0.
//  - Deselect cycle (every non-command cycle): cs_n=1, act_n=1, A=17'h1C000, bg/ba=0.
//  - Request fields are latched on accept and held stable internally. Pin inputs are ignored.
//  - FSM: IDLE -> ACT -> WAIT_RCD -> CAS -> BURST -> PRE -> WAIT_RP -> IDLE.
//  - Accept at edge T. ACT on pins in cycle T+1: cs_n=0, act_n=0, A=row, bg/ba=latched.
//  - CAS in cycle T+1+TRCD: cs_n=0, act_n=1, A[top:top-2]=3'b100 (WR) or 3'b101 (RD).
//    A[COLWIDTH-1:0]=col; all other A bits are 0.
//  - BURST: BL-1 deselect cycles follow the CAS cycle.
//  - PRE in cycle T+1+TRCD+BL: A[top:top-2]=3'b010, A[10]=0 (single bank), same bg/ba.
//  - WAIT_RP: TRP-1 deselect cycles. done=1 and req_ready=1 in cycle T+1+TRCD+BL+TRP.
//  - Back-to-back requests: a new request can be accepted in the same cycle as done.
//    The next ACT then appears one cycle later, so PRE->ACT spacing is exactly TRP+1.
//  - Wait counters count down from the parameter value minus 1. TRCD=1 or TRP=1 skips the
//    wait state. Counter width is $clog2 of the maximum of TRCD, TRP and BL, plus 1.
//  - req_valid deasserting before acceptance is legal; nothing is latched in that case.
//  - Reset mid-operation: in the next cycle the pins show deselect and req_ready=1.
//    No PRE is issued. The open-row table (see CONFIGURATION) is cleared.
// CONFIGURATION
//  OPEN_PAGE_EN undefined: closed-page policy. Every request runs ACT..PRE as above.
//  OPEN_PAGE_EN defined: a per-bank table holds a valid bit and a row, with
//  2^(BGWIDTH+BAWIDTH) entries, all cleared on reset. No PRE is issued after the burst.
//  - Hit (valid and row match): CAS at T+1; done at T+1+BL.
//  - Closed bank (not valid): ACT at T+1, CAS at T+1+TRCD, done at T+1+TRCD+BL.
//    The table entry is set.
//  - Miss (valid, different row): PRE at T+1, ACT at T+1+TRP, CAS at T+1+TRP+TRCD,
//    done at T+1+TRP+TRCD+BL. The table entry is updated to the new row.
// TESTING
//  1 Reset: hold rst_n=0 for 2 cycles, req_valid=1 -> cke=1, cs_n=1, act_n=1, A=17'h1C000,
//    req_ready=1, no accept.
//  2 Write wr=1, bg=1, ba=1, row=1, col=8, accepted at T.
//    -> T+1: act_n=0, A=17'h00001, bg=1, ba=1.
//    -> T+5: A=17'b10000000000001000.
//    -> T+13: A=17'b01000000000000000.
//    -> T+17: done=1.
//  3 Read, same fields -> T+5: A=17'b10100000000001000. The decoder reports rd_o_wr[1][1]=0
//    and ColId 8..15 over 8 cycles.
//  4 Back-to-back: req_valid held high with two requests.
//    -> req_ready=0 for T+1..T+16; second accept at T+17; second ACT at T+18.
//  5 rst_n=0 for one cycle at T+7 (mid-burst) -> T+8: deselect, req_ready=1.
//    Nothing issued after the reset cycle.
//  6 OPEN_PAGE_EN: write row 1 bank(1,1), then read row 1, then read row 2, same bank.
//    -> second request: CAS at T'+1, no ACT.
//    -> third request: PRE at T''+1, ACT at T''+5, CAS at T''+9.

Source files
------------

// File: rtl/cmd_issuer.sv
// rtl/cmd_issuer.sv - DDR4 ACT -> RD/WR -> PRE command sequencer; define OPEN_PAGE_EN for open-page policy
module cmd_issuer #(
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int BL        = 8,
    parameter int TRCD      = 4,
    parameter int TRP       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rd_o_wr,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic [ADDRWIDTH-1:0] A,
    output logic                 busy,
    output logic                 done
);
    localparam int MAXT = (TRCD > TRP) ? ((TRCD > BL) ? TRCD : BL) : ((TRP > BL) ? TRP : BL);
    localparam int CW   = $clog2(MAXT) + 1;
    localparam logic [ADDRWIDTH-1:0] A_DESEL = {3'b111, {(ADDRWIDTH-3){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_WAIT_RCD, S_CAS, S_BURST, S_PRE, S_WAIT_RP
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            accept;

    logic                 lat_wr, cur_wr;
    logic [BGWIDTH-1:0]   lat_bg, cur_bg;
    logic [BAWIDTH-1:0]   lat_ba, cur_ba;
    logic [ADDRWIDTH-1:0] lat_row, cur_row;
    logic [COLWIDTH-1:0]  lat_col, cur_col;

    logic                 cs_n_nx, act_n_nx;
    logic [BGWIDTH-1:0]   bg_nx;
    logic [BAWIDTH-1:0]   ba_nx;
    logic [ADDRWIDTH-1:0] a_nx;

    assign accept = req_valid & req_ready;

    // Pins are registered from the next state, so a fresh request's fields bypass the latch.
    assign cur_wr  = accept ? req_rd_o_wr : lat_wr;
    assign cur_bg  = accept ? req_bg      : lat_bg;
    assign cur_ba  = accept ? req_ba      : lat_ba;
    assign cur_row = accept ? req_row     : lat_row;
    assign cur_col = accept ? req_col     : lat_col;

`ifdef OPEN_PAGE_EN
    localparam int NBANK = 2 ** (BGWIDTH + BAWIDTH);
    logic                 tbl_valid [NBANK];
    logic [ADDRWIDTH-1:0] tbl_row   [NBANK];
    logic [BGWIDTH+BAWIDTH-1:0] req_idx;
    logic                 tbl_hit;
    assign req_idx = {req_bg, req_ba};
    assign tbl_hit = tbl_valid[req_idx] && (tbl_row[req_idx] == req_row);
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef OPEN_PAGE_EN
                    if (tbl_hit)                 state_nx = S_CAS;
                    else if (tbl_valid[req_idx]) state_nx = S_PRE;
                    else                         state_nx = S_ACT;
`else
                    state_nx = S_ACT;
`endif
                end
            end
            S_ACT: begin
                if (TRCD > 1) begin
                    state_nx = S_WAIT_RCD;
                    cnt_nx   = CW'(TRCD - 1);
                end else begin
                    state_nx = S_CAS;
                end
            end
            S_WAIT_RCD: begin
                if (cnt <= CW'(1)) state_nx = S_CAS;
                else               cnt_nx   = cnt - CW'(1);
            end
            S_CAS: begin
                if (BL > 1) begin
                    state_nx = S_BURST;
                    cnt_nx   = CW'(BL - 1);
                end else begin
`ifdef OPEN_PAGE_EN
                    state_nx = S_IDLE;
`else
                    state_nx = S_PRE;
`endif
                end
            end
            S_BURST: begin
                if (cnt <= CW'(1)) begin
`ifdef OPEN_PAGE_EN
                    state_nx = S_IDLE;
`else
                    state_nx = S_PRE;
`endif
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_PRE: begin
                if (TRP > 1) begin
                    state_nx = S_WAIT_RP;
                    cnt_nx   = CW'(TRP - 1);
                end else begin
`ifdef OPEN_PAGE_EN
                    state_nx = S_ACT;
`else
                    state_nx = S_IDLE;
`endif
                end
            end
            S_WAIT_RP: begin
                if (cnt <= CW'(1)) begin
`ifdef OPEN_PAGE_EN
                    state_nx = S_ACT;
`else
                    state_nx = S_IDLE;
`endif
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cs_n_nx  = 1'b1;
        act_n_nx = 1'b1;
        bg_nx    = '0;
        ba_nx    = '0;
        a_nx     = A_DESEL;
        case (state_nx)
            S_ACT: begin
                cs_n_nx  = 1'b0;
                act_n_nx = 1'b0;
                bg_nx    = cur_bg;
                ba_nx    = cur_ba;
                a_nx     = cur_row;
            end
            S_CAS: begin
                cs_n_nx                = 1'b0;
                bg_nx                  = cur_bg;
                ba_nx                  = cur_ba;
                a_nx                   = '0;
                a_nx[ADDRWIDTH-1 -: 3] = {2'b10, ~cur_wr};
                a_nx[COLWIDTH-1:0]     = cur_col;
            end
            S_PRE: begin
                cs_n_nx                = 1'b0;
                bg_nx                  = cur_bg;
                ba_nx                  = cur_ba;
                a_nx                   = '0;
                a_nx[ADDRWIDTH-1 -: 3] = 3'b010;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_wr    <= 1'b0;
            lat_bg    <= '0;
            lat_ba    <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
            cke       <= 1'b1;
            cs_n      <= 1'b1;
            act_n     <= 1'b1;
            bg        <= '0;
            ba        <= '0;
            A         <= A_DESEL;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef OPEN_PAGE_EN
            for (int i = 0; i < NBANK; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_row[i]   <= '0;
            end
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cke       <= 1'b1;
            cs_n      <= cs_n_nx;
            act_n     <= act_n_nx;
            bg        <= bg_nx;
            ba        <= ba_nx;
            A         <= a_nx;
            req_ready <= (state_nx == S_IDLE);
            busy      <= (state_nx != S_IDLE);
            done      <= (state_nx == S_IDLE) && (state != S_IDLE);
            if (accept) begin
                lat_wr  <= req_rd_o_wr;
                lat_bg  <= req_bg;
                lat_ba  <= req_ba;
                lat_row <= req_row;
                lat_col <= req_col;
`ifdef OPEN_PAGE_EN
                tbl_valid[req_idx] <= 1'b1;
                tbl_row[req_idx]   <= req_row;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cmd_issuer.sv
// tb/tb_cmd_issuer.sv - directed self-checking bench for cmd_issuer (closed- and open-page builds)
module tb_cmd_issuer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rd_o_wr = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        cke, cs_n, act_n, busy, done;
    logic [1:0]  bg, ba;
    logic [16:0] A;

    int n_checks = 0;
    int n_pass   = 0;
    int ncs      = 0;
    int nrdy0    = 0;
    int ndone    = 0;

    always #5 clk = ~clk;

    cmd_issuer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd_o_wr(req_rd_o_wr), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .bg(bg), .ba(ba), .A(A), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] g, input logic [1:0] b,
                         input logic [16:0] r, input logic [9:0] c);
        req_rd_o_wr = wr;
        req_bg      = g;
        req_ba      = b;
        req_row     = r;
        req_col     = c;
        req_valid   = 1'b1;
        step();
        req_valid   = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with a request pending
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_row = 17'h3;
        step();
        step();
        check("rst_cke", cke, 1);
        check("rst_cs_n", cs_n, 1);
        check("rst_act_n", act_n, 1);
        check("rst_A", A, 17'h1C000);
        check("rst_ready", req_ready, 1);
        check("rst_done", done, 0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("rst_no_accept_cs", cs_n, 1);
        check("rst_no_accept_rdy", req_ready, 1);

`ifndef OPEN_PAGE_EN
        // Write bg=1 ba=1 row=1 col=8
        issue(1'b1, 2'd1, 2'd1, 17'd1, 10'd8);
        ncs = 0;
        for (int k = 1; k <= 17; k++) begin
            if (!cs_n) ncs++;
            case (k)
                1: begin
                    check("wr_act_n", act_n, 0);
                    check("wr_act_A", A, 17'h00001);
                    check("wr_act_bg", bg, 1);
                    check("wr_act_ba", ba, 1);
                    check("wr_busy", busy, 1);
                end
                3: check("wr_desel_A", A, 17'h1C000);
                5: begin
                    check("wr_cas_A", A, 17'h10008);
                    check("wr_cas_act_n", act_n, 1);
                    check("wr_cas_cs_n", cs_n, 0);
                end
                13: check("wr_pre_A", A, 17'h08000);
                16: check("wr_done_early", done, 0);
                17: begin
                    check("wr_done", done, 1);
                    check("wr_ready", req_ready, 1);
                end
                default: ;
            endcase
            if (k < 17) step();
        end
        check("wr_cmd_count", ncs, 3);

        // Read, same fields
        issue(1'b0, 2'd1, 2'd1, 17'd1, 10'd8);
        for (int k = 2; k <= 17; k++) step();
        check("rd_done", done, 1);

        issue(1'b0, 2'd1, 2'd1, 17'd1, 10'd8);
        for (int k = 2; k <= 5; k++) step();
        check("rd_cas_A", A, 17'h14008);
        for (int k = 6; k <= 17; k++) step();
        check("rd2_done", done, 1);

        // Back-to-back with req_valid held high
        req_rd_o_wr = 1'b1; req_bg = 2'd1; req_ba = 2'd0; req_row = 17'd9; req_col = 10'd0;
        req_valid = 1'b1;
        step();
        req_bg = 2'd2; req_ba = 2'd3; req_row = 17'd5; req_col = 10'd3;
        nrdy0 = 0;
        for (int k = 1; k <= 16; k++) begin
            if (!req_ready) nrdy0++;
            step();
        end
        check("b2b_ready_low", nrdy0, 16);
        check("b2b_ready_T17", req_ready, 1);
        check("b2b_done_T17", done, 1);
        step();
        req_valid = 1'b0;
        check("b2b_act_n", act_n, 0);
        check("b2b_act_A", A, 17'd5);
        check("b2b_act_bg", bg, 2);
        check("b2b_act_ba", ba, 3);
        for (int k = 19; k <= 34; k++) step();
        check("b2b_done2", done, 1);

        // Reset mid-burst
        issue(1'b1, 2'd1, 2'd1, 17'd1, 10'd8);
        for (int k = 2; k <= 7; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_cs_n", cs_n, 1);
        check("mid_rst_A", A, 17'h1C000);
        check("mid_rst_ready", req_ready, 1);
        ncs = 0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!cs_n) ncs++;
            if (done) ndone++;
        end
        check("mid_rst_no_cmd", ncs, 0);
        check("mid_rst_no_done", ndone, 0);
`else
        // Closed bank: ACT, CAS, done at T+13
        issue(1'b1, 2'd1, 2'd1, 17'd1, 10'd8);
        check("op1_act_n", act_n, 0);
        check("op1_act_A", A, 17'h00001);
        for (int k = 2; k <= 5; k++) step();
        check("op1_cas_A", A, 17'h10008);
        for (int k = 6; k <= 13; k++) step();
        check("op1_done", done, 1);
        // Hit: CAS immediately
        issue(1'b0, 2'd1, 2'd1, 17'd1, 10'd8);
        check("op2_cs_n", cs_n, 0);
        check("op2_act_n", act_n, 1);
        check("op2_cas_A", A, 17'h14008);
        for (int k = 2; k <= 9; k++) step();
        check("op2_done", done, 1);
        // Miss: PRE, ACT, CAS
        issue(1'b0, 2'd1, 2'd1, 17'd2, 10'd8);
        check("op3_pre_cs_n", cs_n, 0);
        check("op3_pre_A", A, 17'h08000);
        for (int k = 2; k <= 5; k++) step();
        check("op3_act_n", act_n, 0);
        check("op3_act_A", A, 17'h00002);
        for (int k = 6; k <= 9; k++) step();
        check("op3_cas_A", A, 17'h14008);
        for (int k = 10; k <= 17; k++) step();
        check("op3_done", done, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
